// File: rtl/distance_capture.sv
// Multi-channel distance capture with optional per-channel moving average and
// round-robin valid/ready delivery. Define DISTANCE_CAPTURE_AVG_EN for averaging.
module distance_capture #(
  parameter int unsigned CH       = 4,
  parameter int unsigned DW       = 32,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [CH*DW-1:0]                    i_distance,
  input  logic [CH-1:0]                       i_read,
  input  logic                                i_idle,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] o_ch,
  output logic [DW-1:0]                       o_distance,
  output logic [CH-1:0]                       o_done,
  output logic [CH-1:0]                       o_overrun
);

  localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;

  logic [DW-1:0] avg [CH];
  logic [CH-1:0] pending;
  logic [CH-1:0] load_hit;
  logic [CW-1:0] last_grant;
  logic [CW-1:0] grant;
  logic [CW-1:0] idx;
  logic          found;
  logic          load;

  // Parameter range marker: CH 1..16, AVG_LOG2 0..4 are the supported ranges.
  if (CH < 1 || CH > 16 || AVG_LOG2 > 4) begin : g_unsupported_params
  end

`ifdef DISTANCE_CAPTURE_AVG_EN
  localparam int unsigned WIN = 1 << AVG_LOG2;
  localparam int unsigned PW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned SW  = DW + AVG_LOG2;

  for (genvar c = 0; c < CH; c++) begin : g_chan
    logic [DW-1:0] ring [WIN];
    logic [PW-1:0] wptr;
    logic [SW-1:0] sum;
    logic          primed;
    logic [DW-1:0] sample;
    logic          first;

    assign sample = i_distance[c*DW +: DW];
    // An idle in the same cycle restarts the channel, so the sample seeds it.
    assign first  = i_idle || !primed;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        primed <= 1'b0;
        wptr   <= '0;
        sum    <= '0;
        for (int k = 0; k < int'(WIN); k++) ring[k] <= '0;
      end else if (i_read[c]) begin
        if (first) begin
          for (int k = 0; k < int'(WIN); k++) ring[k] <= sample;
          sum    <= SW'(sample) << AVG_LOG2;
          wptr   <= '0;
          primed <= 1'b1;
        end else begin
          ring[wptr] <= sample;
          sum        <= sum + SW'(sample) - SW'(ring[wptr]);
          wptr       <= (wptr == PW'(WIN - 1)) ? '0 : wptr + PW'(1);
        end
      end else if (i_idle) begin
        primed <= 1'b0;
        wptr   <= '0;
        sum    <= '0;
      end
    end

    assign avg[c] = DW'(sum >> AVG_LOG2);
  end
`else
  for (genvar c = 0; c < CH; c++) begin : g_chan
    logic [DW-1:0] latest;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        latest <= '0;
      end else if (i_read[c]) begin
        latest <= i_distance[c*DW +: DW];
      end else if (i_idle) begin
        latest <= '0;
      end
    end

    assign avg[c] = latest;
  end
`endif

  // Output register accepts a new word when empty or in the handshake cycle.
  assign load = !o_valid || i_ready;

  // Round-robin: first pending channel strictly after the last grant.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= CH; i++) begin
      idx = CW'((32'(last_grant) + i) % CH);
      if (!found && pending[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    load_hit = '0;
    if (load && found) load_hit[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid    <= 1'b0;
      o_ch       <= '0;
      o_distance <= '0;
      last_grant <= CW'(CH - 1);
    end else if (i_idle) begin
      o_valid    <= 1'b0;
      o_ch       <= '0;
      o_distance <= '0;
    end else if (load) begin
      if (found) begin
        o_valid    <= 1'b1;
        o_ch       <= grant;
        o_distance <= avg[grant];
        last_grant <= grant;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

  // A capture on the channel being loaded re-arms pending instead of overrunning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      o_done    <= '0;
      o_overrun <= '0;
    end else if (i_idle) begin
      pending   <= i_read;
      o_done    <= i_read;
      o_overrun <= '0;
    end else begin
      pending   <= (pending & ~load_hit) | i_read;
      o_done    <= o_done | i_read;
      o_overrun <= o_overrun | (i_read & pending & ~load_hit);
    end
  end

endmodule

// File: tb/tb_distance_capture.sv
// Self-checking bench for distance_capture against a queue-based reference model.
module tb_distance_capture;
  localparam int unsigned CH = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned CW = 2;
`ifdef DISTANCE_CAPTURE_AVG_EN
  localparam int unsigned M_WIN = 1 << AVG_LOG2;
`else
  localparam int unsigned M_WIN = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH*DW-1:0]  i_distance;
  logic [CH-1:0]     i_read;
  logic              i_idle;
  logic              i_ready;
  logic              o_valid;
  logic [CW-1:0]     o_ch;
  logic [DW-1:0]     o_distance;
  logic [CH-1:0]     o_done;
  logic [CH-1:0]     o_overrun;

  distance_capture #(.CH(CH), .DW(DW), .AVG_LOG2(AVG_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .i_distance(i_distance), .i_read(i_read),
    .i_idle(i_idle), .o_valid(o_valid), .i_ready(i_ready), .o_ch(o_ch),
    .o_distance(o_distance), .o_done(o_done), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: history of the last M_WIN samples per channel.
  longint unsigned hist [CH][$];
  logic [CH-1:0]   m_pend, m_done, m_ovr;
  logic            m_valid;
  int              m_ch;
  longint unsigned m_dist;
  int              m_last;

  function automatic longint unsigned m_avg(int c);
    longint unsigned s = 0;
    for (int k = 0; k < hist[c].size(); k++) s += hist[c][k];
    return s / M_WIN;
  endfunction

  task automatic m_absorb(int c, longint unsigned v);
    if (hist[c].size() == 0) begin
      for (int k = 0; k < int'(M_WIN); k++) hist[c].push_back(v);
    end else begin
      hist[c].push_back(v);
      void'(hist[c].pop_front());
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < int'(CH); c++) hist[c].delete();
    m_pend = '0; m_done = '0; m_ovr = '0;
    m_valid = 1'b0; m_ch = 0; m_dist = 0; m_last = CH - 1;
  endtask

  task automatic model_step(input logic [CH-1:0] rd, input logic idl, input logic rdy);
    int g;
    if (idl) begin
      for (int c = 0; c < int'(CH); c++) hist[c].delete();
      m_pend = rd; m_done = rd; m_ovr = '0;
      m_valid = 1'b0; m_ch = 0; m_dist = 0;
      for (int c = 0; c < int'(CH); c++)
        if (rd[c]) m_absorb(c, longint'(i_distance[c*DW +: DW]));
    end else begin
      g = -1;
      if (!m_valid || rdy) begin
        for (int i = 1; i <= int'(CH); i++)
          if (g < 0 && m_pend[(m_last + i) % CH]) g = (m_last + i) % CH;
        if (g >= 0) begin
          m_valid = 1'b1; m_ch = g; m_dist = m_avg(g); m_pend[g] = 1'b0; m_last = g;
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int c = 0; c < int'(CH); c++) begin
        if (rd[c]) begin
          if (m_pend[c]) m_ovr[c] = 1'b1;
          m_absorb(c, longint'(i_distance[c*DW +: DW]));
          m_pend[c] = 1'b1;
          m_done[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic set_dist(input int c, input logic [DW-1:0] v);
    i_distance[c*DW +: DW] = v;
  endtask

  // One clock: drive at negedge, update model at posedge, return at next negedge.
  task automatic tick(input logic [CH-1:0] rd, input logic idl, input logic rdy);
    i_read = rd; i_idle = idl; i_ready = rdy;
    @(posedge clk);
    model_step(rd, idl, rdy);
    @(negedge clk);
    i_read = '0; i_idle = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_read = '0; i_idle = 1'b0; i_ready = 1'b0; i_distance = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_tests++; if (o_ch !== '0) begin n_fail++; $display("FAIL reset_ch: got %0d expected 0", o_ch); end
    n_tests++; if (o_distance !== '0) begin n_fail++; $display("FAIL reset_distance: got %0d expected 0", o_distance); end
    n_tests++; if ({o_done, o_overrun} !== '0) begin n_fail++; $display("FAIL reset_flags: got done=%b ovr=%b expected 0", o_done, o_overrun); end
    rst_n = 1'b1;
  endtask

  task automatic test_first_capture();
    set_dist(0, 100);
    tick(4'b0001, 1'b0, 1'b1);
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL first_latency: valid got %b expected 0 one cycle after strobe", o_valid); end
    tick(4'b0000, 1'b0, 1'b1);
    n_tests++; if (o_valid !== 1'b1 || o_ch !== 2'd0 || o_distance !== 32'd100)
      begin n_fail++; $display("FAIL first_word: got v=%b ch=%0d d=%0d expected v=1 ch=0 d=100", o_valid, o_ch, o_distance); end
    n_tests++; if (o_done !== 4'b0001) begin n_fail++; $display("FAIL first_done: got %b expected 0001", o_done); end
    tick(4'b0000, 1'b0, 1'b1);
  endtask

  task automatic test_average();
    int unsigned samp [5] = '{100, 200, 200, 200, 200};
`ifdef DISTANCE_CAPTURE_AVG_EN
    int unsigned expv [5] = '{100, 125, 150, 175, 200};
`else
    int unsigned expv [5] = '{100, 200, 200, 200, 200};
`endif
    tick(4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      set_dist(1, samp[k]);
      tick(4'b0010, 1'b0, 1'b1);
      tick(4'b0000, 1'b0, 1'b1);
      n_tests++; if (o_valid !== 1'b1 || o_ch !== 2'd1 || o_distance !== expv[k] || longint'(o_distance) !== m_dist)
        begin n_fail++; $display("FAIL average_%0d: got v=%b ch=%0d d=%0d expected v=1 ch=1 d=%0d", k, o_valid, o_ch, o_distance, expv[k]); end
    end
    tick(4'b0000, 1'b0, 1'b1);
  endtask

  task automatic test_all_channels();
    pulse_reset();
    for (int c = 0; c < int'(CH); c++) set_dist(c, $urandom_range(1, 5000));
    tick(4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < int'(CH); i++) begin
      tick(4'b0000, 1'b0, 1'b1);
      n_tests++; if (o_valid !== 1'b1 || o_ch !== CW'(i) || longint'(o_distance) !== m_dist)
        begin n_fail++; $display("FAIL rr_order_%0d: got v=%b ch=%0d d=%0d expected v=1 ch=%0d d=%0d", i, o_valid, o_ch, o_distance, i, m_dist); end
    end
    tick(4'b0000, 1'b0, 1'b1);
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: valid got %b expected 0", o_valid); end
  endtask

  task automatic test_overrun();
    longint unsigned held;
    tick(4'b0000, 1'b1, 1'b0);
    set_dist(2, $urandom_range(1, 60000));
    tick(4'b0100, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    held = m_dist;
    set_dist(2, $urandom_range(1, 60000));
    tick(4'b0100, 1'b0, 1'b0);
    n_tests++; if (o_overrun[2] !== 1'b0) begin n_fail++; $display("FAIL overrun_early: got %b expected 0", o_overrun[2]); end
    set_dist(2, $urandom_range(1, 60000));
    tick(4'b0100, 1'b0, 1'b0);
    n_tests++; if (o_overrun !== 4'b0100 || o_overrun !== m_ovr) begin n_fail++; $display("FAIL overrun_set: got %b expected 0100", o_overrun); end
    n_tests++; if (o_valid !== 1'b1 || o_ch !== 2'd2 || longint'(o_distance) !== held)
      begin n_fail++; $display("FAIL overrun_hold: got v=%b ch=%0d d=%0d expected v=1 ch=2 d=%0d", o_valid, o_ch, o_distance, held); end
  endtask

  task automatic test_idle_inflight();
    set_dist(3, 777);
    tick(4'b1000, 1'b0, 1'b0);
    tick(4'b1000, 1'b0, 1'b0);
    set_dist(3, 50);
    tick(4'b1000, 1'b1, 1'b0);
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL idle_drop: valid got %b expected 0", o_valid); end
    n_tests++; if (o_done !== 4'b1000 || o_overrun !== 4'b0000)
      begin n_fail++; $display("FAIL idle_flags: got done=%b ovr=%b expected done=1000 ovr=0000", o_done, o_overrun); end
    tick(4'b0000, 1'b0, 1'b1);
    n_tests++; if (o_valid !== 1'b1 || o_ch !== 2'd3 || o_distance !== 32'd50)
      begin n_fail++; $display("FAIL idle_next: got v=%b ch=%0d d=%0d expected v=1 ch=3 d=50", o_valid, o_ch, o_distance); end
    tick(4'b0000, 1'b0, 1'b1);
  endtask

  task automatic test_overwrite();
`ifdef DISTANCE_CAPTURE_AVG_EN
    logic [DW-1:0] expd = 32'd15;
`else
    logic [DW-1:0] expd = 32'd30;
`endif
    tick(4'b0000, 1'b1, 1'b0);
    set_dist(1, 7);
    tick(4'b0010, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    set_dist(0, 10);
    tick(4'b0001, 1'b0, 1'b0);
    set_dist(0, 30);
    tick(4'b0001, 1'b0, 1'b0);
    n_tests++; if (o_overrun !== 4'b0001) begin n_fail++; $display("FAIL overwrite_ovr: got %b expected 0001", o_overrun); end
    tick(4'b0000, 1'b0, 1'b1);
    n_tests++; if (o_valid !== 1'b1 || o_ch !== 2'd0 || o_distance !== expd)
      begin n_fail++; $display("FAIL overwrite_word: got v=%b ch=%0d d=%0d expected v=1 ch=0 d=%0d", o_valid, o_ch, o_distance, expd); end
    tick(4'b0000, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    set_dist(1, 300); set_dist(2, 400);
    tick(4'b0110, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (o_valid !== 1'b0 || o_done !== 4'b0000 || o_distance !== '0)
      begin n_fail++; $display("FAIL async_reset: got v=%b done=%b d=%0d expected all 0", o_valid, o_done, o_distance); end
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    set_dist(2, 4242);
    tick(4'b0100, 1'b0, 1'b1);
    tick(4'b0000, 1'b0, 1'b1);
    n_tests++; if (o_valid !== 1'b1 || o_ch !== 2'd2 || o_distance !== 32'd4242)
      begin n_fail++; $display("FAIL post_reset_capture: got v=%b ch=%0d d=%0d expected v=1 ch=2 d=4242", o_valid, o_ch, o_distance); end
    tick(4'b0000, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [CH-1:0] rd;
    logic idl, rdy;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < int'(CH); c++) set_dist(c, $urandom);
      for (int c = 0; c < int'(CH); c++) rd[c] = ($urandom_range(0, 2) == 0);
      idl = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tick(rd, idl, rdy);
      n_tests++; if (o_valid !== m_valid || o_done !== m_done || o_overrun !== m_ovr)
        begin n_fail++; $display("FAIL random_flags@%0d: got v=%b done=%b ovr=%b expected v=%b done=%b ovr=%b", n, o_valid, o_done, o_overrun, m_valid, m_done, m_ovr); end
      if (m_valid) begin
        n_tests++; if (o_ch !== CW'(m_ch) || longint'(o_distance) !== m_dist)
          begin n_fail++; $display("FAIL random_word@%0d: got ch=%0d d=%0d expected ch=%0d d=%0d", n, o_ch, o_distance, m_ch, m_dist); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_first_capture();
    test_average();
    test_all_channels();
    test_overrun();
    test_idle_inflight();
    test_overwrite();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
